// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 pixel capture block.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VS  = 2'd1,
        WAIT_FRM = 2'd2,
        ACTIVE   = 2'd3
    } cap_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Multi-flop synchronizer for an asynchronous camera signal, with optional
// rise/fall detection on the synchronized value.
module ov7670_sync_edge
    import ov7670_pkg::*;
#(
    parameter int W       = 1,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] stage_q [SYNC_DEPTH];

    // NOTE: non-blocking assignments keep every stage sampling its
    // predecessor's old value, so the chain really is SYNC_DEPTH flops deep.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < SYNC_DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < SYNC_DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign sync_o = stage_q[SYNC_DEPTH-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic [W-1:0] prev_q;

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) prev_q <= '0;
                else         prev_q <= sync_o;
            end

            assign rise_o = sync_o & ~prev_q;
            assign fall_o = ~sync_o & prev_q;
        end else begin : g_no_edge
            assign rise_o = '0;
            assign fall_o = '0;
        end
    endgenerate

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture into the clk domain with x/y and frame markers.
// Define CAPTURE_ERR_EN to add sticky line-length / line-count error flags.
module ov7670_pixel_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          pclk,
    input  logic          href,
    input  logic          vsync,
    input  logic [7:0]    d,
    input  logic          enable,
    output logic          pix_valid,
    output logic [7:0]    pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          sof,
    output logic          eol,
    output logic          eof,
    output logic          busy
`ifdef CAPTURE_ERR_EN
    ,
    input  logic          err_clr,
    output logic          err_line,
    output logic          err_frame
`endif
);

    localparam logic [XW-1:0] X_SAT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_SAT  = YW'(V_ACTIVE);

    logic       pclk_rise, href_s, href_fall, vsync_rise, vsync_fall;
    logic [7:0] d_s;
    logic       pclk_s_unused, pclk_fall_unused, href_rise_unused, vsync_s_unused;
    logic [7:0] d_rise_unused, d_fall_unused;

    ov7670_sync_edge u_pclk_sync (
        .clk(clk), .reset_(reset_), .async_i(pclk),
        .sync_o(pclk_s_unused), .rise_o(pclk_rise), .fall_o(pclk_fall_unused)
    );
    ov7670_sync_edge u_href_sync (
        .clk(clk), .reset_(reset_), .async_i(href),
        .sync_o(href_s), .rise_o(href_rise_unused), .fall_o(href_fall)
    );
    ov7670_sync_edge u_vsync_sync (
        .clk(clk), .reset_(reset_), .async_i(vsync),
        .sync_o(vsync_s_unused), .rise_o(vsync_rise), .fall_o(vsync_fall)
    );
    ov7670_sync_edge #(.W(8), .EDGE_EN(1'b0)) u_d_sync (
        .clk(clk), .reset_(reset_), .async_i(d),
        .sync_o(d_s), .rise_o(d_rise_unused), .fall_o(d_fall_unused)
    );

    cap_state_e    state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          pix_in, line_end, in_window;
    logic [YW-1:0] y_d;

    // d travels through an identical pipeline, so d_s is aligned with pclk_rise.
    assign pix_in    = pclk_rise & href_s;
    assign line_end  = href_fall & (x_q != '0);
    assign in_window = (x_q < X_SAT) && (y_q < Y_SAT);
    assign y_d       = (line_end && (y_q != Y_SAT)) ? y_q + 1'b1 : y_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            busy      <= (state_q == ACTIVE);
            case (state_q)
                IDLE:     if (enable) state_q <= WAIT_VS;
                WAIT_VS:  if (vsync_rise) state_q <= WAIT_FRM;
                WAIT_FRM: if (vsync_fall) begin
                    x_q     <= '0;
                    y_q     <= '0;
                    state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (pix_in) begin
                        if (in_window) begin
                            pix_valid <= 1'b1;
                            pix_data  <= d_s;
                            pix_x     <= x_q;
                            pix_y     <= y_q;
                            sof       <= (x_q == '0) && (y_q == '0);
                            eol       <= (x_q == X_LAST);
                        end
                        if (x_q != X_SAT) x_q <= x_q + 1'b1;
                    end
                    if (href_fall) begin
                        x_q <= '0;
                        y_q <= y_d;
                    end
                    // Frame end: enable is only looked at here, never mid-frame.
                    if (vsync_rise) begin
                        eof     <= 1'b1;
                        state_q <= enable ? WAIT_FRM : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CAPTURE_ERR_EN
    logic x_ovf_q, line_err_set, frame_err_set;

    // x saturates, so a separate flag remembers pixels beyond H_ACTIVE.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            x_ovf_q <= 1'b0;
        end else if ((state_q == ACTIVE && href_fall) || (state_q == WAIT_FRM && vsync_fall)) begin
            x_ovf_q <= 1'b0;
        end else if (state_q == ACTIVE && pix_in && x_q == X_SAT) begin
            x_ovf_q <= 1'b1;
        end
    end

    assign line_err_set  = (state_q == ACTIVE) && line_end && ((x_q != X_SAT) || x_ovf_q);
    assign frame_err_set = (state_q == ACTIVE) && vsync_rise && (y_d != Y_SAT);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            err_line  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_line  <= (err_line  & ~err_clr) | line_err_set;
            err_frame <= (err_frame & ~err_clr) | frame_err_set;
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed-sequence bench with randomized data/blanking for ov7670_pixel_capture,
// checked against a frame-level reference model of the expected pixel stream.
module tb_ov7670_pixel_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int XW = 10;
    localparam int YW = 9;

    localparam int EV_NONE  = 0;
    localparam int EV_DROP  = 1;
    localparam int EV_RAISE = 2;
    localparam int EV_RST   = 3;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          pclk = 1'b0, href = 1'b0, vsync = 1'b0, enable = 1'b0;
    logic [7:0]    d = '0;
    logic          pix_valid, sof, eol, eof, busy;
    logic [7:0]    pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
`ifdef CAPTURE_ERR_EN
    logic          err_clr = 1'b0;
    logic          err_line, err_frame;
`endif

    always #5 clk = ~clk;

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset_(reset_), .pclk(pclk), .href(href), .vsync(vsync),
        .d(d), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .eof(eof), .busy(busy)
`ifdef CAPTURE_ERR_EN
        , .err_clr(err_clr), .err_line(err_line), .err_frame(err_frame)
`endif
    );

    typedef struct {
        int x;
        int y;
        int data;
        bit sof;
        bit eol;
        int cyc;
    } pix_t;

    pix_t exp_q[$], obs_q[$];
    int   exp_eof_q[$], obs_eof_q[$];
    pix_t mon_p;
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;

    bit   live = 1'b0, armed = 1'b0;
    int   ym = 0;
    bit   exp_err_line = 1'b0, exp_err_frame = 1'b0;
    int   line_len [8];
    int   n_lines = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) begin
            mon_p.x    = int'(pix_x);
            mon_p.y    = int'(pix_y);
            mon_p.data = int'(pix_data);
            mon_p.sof  = sof;
            mon_p.eol  = eol;
            mon_p.cyc  = cyc;
            obs_q.push_back(mon_p);
        end
        if (eof) obs_eof_q.push_back(cyc);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One PCLK period (4 clk): low half then high half; d/href change with the fall.
    task automatic pclk_period(input logic h, input logic [7:0] dv, input bit cap,
                               input int ex, input int ey, input bit do_rst);
        pix_t p;
        @(negedge clk); pclk = 1'b0; href = h; d = dv;
        @(negedge clk);
        @(negedge clk); pclk = 1'b1;
        if (cap) begin
            p.x = ex; p.y = ey; p.data = int'(dv);
            p.sof = (ex == 0) && (ey == 0);
            p.eol = (ex == H - 1);
            p.cyc = cyc + 3;
            exp_q.push_back(p);
        end
        if (do_rst) begin
            reset_ = 1'b0;
            #1;
            check("rst_pix_valid", pix_valid, 0);
            check("rst_pix_x", pix_x, 0);
            check("rst_pix_y", pix_y, 0);
            check("rst_pix_data", pix_data, 0);
            check("rst_busy", busy, 0);
        end
        @(negedge clk); reset_ = 1'b1;
    endtask

    task automatic blank(input int n);
        repeat (n) pclk_period(1'b0, 8'($urandom), 1'b0, 0, 0, 1'b0);
    endtask

    task automatic vsync_pulse();
        @(negedge clk); pclk = 1'b0; href = 1'b0; vsync = 1'b1;
        if (live) begin
            exp_eof_q.push_back(cyc + 3);
            if (ym != V) exp_err_frame = 1'b1;
            live  = 1'b0;
            armed = enable;
        end
        blank(3);
        @(negedge clk); vsync = 1'b0;
        if (armed) begin
            live  = 1'b1;
            armed = 1'b0;
            ym    = 0;
        end
        blank(2);
    endtask

    task automatic send_frame(input bit pattern, input int ev_kind, input int ev_x, input int ev_y);
        for (int l = 0; l < n_lines; l++) begin
            for (int k = 0; k < line_len[l]; k++) begin
                logic [7:0] dv;
                bit         cap, at_ev, rst_here;
                dv       = pattern ? 8'(8 * l + k) : 8'($urandom);
                at_ev    = (l == ev_y) && (k == ev_x);
                rst_here = at_ev && (ev_kind == EV_RST);
                if (at_ev && ev_kind == EV_DROP) enable = 1'b0;
                if (at_ev && ev_kind == EV_RAISE) begin
                    enable = 1'b1;
                    if (!live) armed = 1'b1;
                end
                cap = live && !rst_here && (k < H) && (ym < V);
                pclk_period(1'b1, dv, cap, k, ym, rst_here);
                if (rst_here) begin
                    live = 1'b0;
                    armed = enable;
                    exp_err_line = 1'b0;
                    exp_err_frame = 1'b0;
                end
            end
            if (live && line_len[l] > 0) begin
                if (line_len[l] != H) exp_err_line = 1'b1;
                if (ym < V) ym++;
            end
            blank($urandom_range(1, 3));
            check("busy_in_frame", busy, live);
`ifdef CAPTURE_ERR_EN
            check("err_line", err_line, exp_err_line);
`endif
        end
    endtask

    task automatic compare_frame(input string tag);
        int n;
        repeat (4) @(negedge clk);
        check({tag, "_npix"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_x"},    obs_q[i].x,    exp_q[i].x);
            check({tag, "_y"},    obs_q[i].y,    exp_q[i].y);
            check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
            check({tag, "_sof"},  obs_q[i].sof,  exp_q[i].sof);
            check({tag, "_eol"},  obs_q[i].eol,  exp_q[i].eol);
            check({tag, "_lat"},  obs_q[i].cyc,  exp_q[i].cyc);
        end
        check({tag, "_neof"}, obs_eof_q.size(), exp_eof_q.size());
        n = (obs_eof_q.size() < exp_eof_q.size()) ? obs_eof_q.size() : exp_eof_q.size();
        for (int i = 0; i < n; i++) check({tag, "_eof_lat"}, obs_eof_q[i], exp_eof_q[i]);
`ifdef CAPTURE_ERR_EN
        check({tag, "_err_frame"}, err_frame, exp_err_frame);
`endif
        obs_q.delete();
        exp_q.delete();
        obs_eof_q.delete();
        exp_eof_q.delete();
    endtask

    task automatic set_lines(input int n, input int a, input int b, input int c);
        n_lines = n;
        line_len[0] = a;
        line_len[1] = b;
        line_len[2] = c;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_pix_valid", pix_valid, 0);
        check("reset_pix_data", pix_data, 0);
        check("reset_pix_x", pix_x, 0);
        check("reset_pix_y", pix_y, 0);
        check("reset_sof", sof, 0);
        check("reset_eol", eol, 0);
        check("reset_eof", eof, 0);
        check("reset_busy", busy, 0);
`ifdef CAPTURE_ERR_EN
        check("reset_err_line", err_line, 0);
        check("reset_err_frame", err_frame, 0);
`endif
        reset_ = 1'b1;
        enable = 1'b1;
        armed  = 1'b1;
        blank(3);

        // Two full frames of 8*y+x
        vsync_pulse();
        set_lines(3, 4, 4, 4);
        send_frame(1'b1, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t1_f1");
        check("t1_hold_valid", pix_valid, 0);
        check("t1_hold_x", pix_x, 3);
        check("t1_hold_y", pix_y, 2);
        check("t1_hold_data", pix_data, 19);
        send_frame(1'b1, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t1_f2");

        // Enable dropped at (1,1): frame completes, then idle
        send_frame(1'b0, EV_DROP, 1, 1);
        vsync_pulse();
        compare_frame("t6_frame");
        check("t6_busy_idle", busy, 0);

        // Enable raised mid-frame: that frame is skipped, the next is captured
        send_frame(1'b0, EV_RAISE, 1, 1);
        vsync_pulse();
        compare_frame("t2_partial");
        send_frame(1'b0, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t2_first");

        // Over-long middle line
        set_lines(3, 4, 6, 4);
        send_frame(1'b0, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t3_long");

        // Short frame, then error clear and a good frame
        set_lines(2, 4, 4, 0);
        send_frame(1'b0, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t4_short");
`ifdef CAPTURE_ERR_EN
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        exp_err_line  = 1'b0;
        exp_err_frame = 1'b0;
        @(negedge clk);
        check("t4_clr_line", err_line, exp_err_line);
        check("t4_clr_frame", err_frame, exp_err_frame);
`endif
        set_lines(3, 4, 4, 4);
        send_frame(1'b0, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t4_good");

        // Reset pulse at (2,1), resume only after a full vsync cycle
        send_frame(1'b0, EV_RST, 2, 1);
        vsync_pulse();
        compare_frame("t5_cut");
        send_frame(1'b0, EV_NONE, 0, 0);
        vsync_pulse();
        compare_frame("t5_resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_pixel_capture.md
# ov7670_pixel_capture

- Downstream stage of the OV7670 camera driver: consumes the camera's parallel pixel bus (PCLK, HREF, VSYNC, D[7:0]) and emits a raw 8-bit Bayer pixel stream in the system `clk` domain.
- Each pixel carries x/y coordinates and frame/line markers for the demosaicing stage.
- PCLK is treated as data, never as a clock: it is synchronized and edge-detected in `clk`.
- Requires `clk` ≥ 4× PCLK frequency.

## Interface

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- XW, 10, width of pix_x
- YW, 9, width of pix_y

Ports:
- clk  in  1  system clock; one clock domain
- reset_  in  1  asynchronous, active-low reset
- pclk  in  1  camera pixel clock, asynchronous
- href  in  1  camera line-valid, asynchronous
- vsync  in  1  camera frame sync, asynchronous, active-high
- d  in  8  camera pixel data, asynchronous
- enable  in  1  arm capture; sampled only at frame boundaries
- pix_valid  out  1  one-cycle strobe, pixel present
- pix_data  out  8  raw Bayer byte
- pix_x  out  XW  column, 0..H_ACTIVE-1
- pix_y  out  YW  row, 0..V_ACTIVE-1
- sof  out  1  with the pix_valid of pixel (0,0)
- eol  out  1  with the pix_valid where pix_x == H_ACTIVE-1
- eof  out  1  one-cycle pulse at the vsync rise that ends a captured frame
- busy  out  1  high in ACTIVE state
- err_clr  in  1  clears sticky errors (CAPTURE_ERR_EN only)
- err_line  out  1  sticky line-length error (CAPTURE_ERR_EN only)
- err_frame  out  1  sticky line-count error (CAPTURE_ERR_EN only)

## Operation

- pclk, href, vsync and d each pass through an identical 2-flop synchronizer, so data stays aligned with its strobes. d is stable around a PCLK rise, so it is safe to capture.
- Edge detect on the synchronized signals: pclk rise, href fall, vsync rise, vsync fall.
- FSM states:
  - IDLE: stays here while `enable` = 0. When `enable` = 1, go to WAIT_VS.
  - WAIT_VS: wait for a vsync rise, then go to WAIT_FRM. This guarantees capture never starts mid-frame.
  - WAIT_FRM: on vsync fall, clear x and y and go to ACTIVE.
  - ACTIVE: on each pclk rise with href = 1, capture one pixel (see below).
    - On href fall: if the line had ≥1 pixel, y += 1 (saturating at V_ACTIVE); x ← 0.
    - On vsync rise: pulse eof; go to WAIT_FRM if `enable` = 1, else IDLE.
- Pixel capture in ACTIVE:
  - If x < H_ACTIVE and y < V_ACTIVE: emit the pixel.
  - Otherwise discard it (no pix_valid).
  - In both cases x increments, saturating at H_ACTIVE.
- Deasserting `enable` mid-frame has no effect until the frame ends; the current frame completes.
- Simultaneous href fall and vsync rise: the y update happens first and eof still pulses in the same cycle. The y value is don't-care afterwards.
- A pclk rise in the same cycle as an href fall is not captured: href is low.

## Timing

- Reset values: all outputs 0; FSM = IDLE; x = 0, y = 0; synchronizers 0.
- Latency: a pin-level pclk rise causes pix_valid 3 clk cycles later:
  - 2 synchronizer cycles;
  - 1 registered-output cycle.
- pix_data, pix_x and pix_y are registered. They are valid only while pix_valid = 1 and hold their value otherwise.
- sof, eol and pix_valid are single-cycle strobes in the same cycle.
- eof asserts 3 cycles after the pin-level vsync rise.
- busy is registered and follows the FSM state with 1-cycle latency.
- Reset asserted mid-frame: immediate return to reset values. After release, capture resumes only through WAIT_VS, so no partial frame is emitted.

## Configuration

- Macro: CAPTURE_ERR_EN.
- Defined:
  - On an href fall in ACTIVE where the line had ≥1 pixel and the pre-saturation x count ≠ H_ACTIVE: set err_line.
  - At eof where the y count ≠ V_ACTIVE: set err_frame.
  - Both errors are sticky until err_clr = 1 or reset.
  - If err_clr and a set condition occur in the same cycle, set wins.
- Undefined: the error logic and ports err_clr, err_line, err_frame are absent. The x/y saturation counters remain.

## Structure

- Package `ov7670_pkg`:
  - FSM state enum (IDLE, WAIT_VS, WAIT_FRM, ACTIVE);
  - default H_ACTIVE and V_ACTIVE constants;
  - synchronizer depth constant (2).
- Sub-module `ov7670_sync_edge`:
  - 2-flop synchronizer plus rise/fall detect;
  - one instance per control signal;
  - the d bus uses an identical width-parameterized instance without edge outputs.

## Test plan

All scenarios use H_ACTIVE = 4, V_ACTIVE = 3 and PCLK = clk/4.

1. Enable, drive two full frames of data = 8·y + x.
   - Expect 12 pix_valid per frame with the correct x/y/data.
   - sof at (0,0); eol at x = 3; one eof per frame.
2. Enable asserted mid-frame.
   - No pix_valid until after the next vsync rise then fall.
   - First emitted pixel has sof and coordinates (0,0).
3. Line with 6 PCLK rises.
   - Pixels 4 and 5 are discarded.
   - y still increments by 1.
   - err_line = 1 with CAPTURE_ERR_EN defined.
4. Frame with 2 lines.
   - eof pulses.
   - err_frame = 1; err_clr clears it; err_frame stays 0 on the next good frame.
5. reset_ low for 1 cycle at pixel (2,1).
   - All outputs go to 0 immediately.
   - Next output starts at a fresh sof after a full vsync cycle.
6. enable dropped at pixel (1,1).
   - Frame completes with all 12 pixels and an eof.
   - FSM goes to IDLE and busy = 0; no further pix_valid.
